fixed_point_accumulator: RTL

- Streaming accumulator downstream of the Q9.7 fixed-point multiplier (16-bit signed, 7 fractional bits, sticky overflow flag).
- Sums a programmed number of product terms onto an initial value, e.g. y + Σ h·f_i for an ODE step.
- Uses a guard-bit internal accumulator and saturates once to 16 bits at the end.
- Reports a sticky overflow combining upstream multiplier overflow and final saturation.

---
 rtl/fixed_point_pkg.sv | 24 ++
 rtl/fixed_point_saturate.sv | 30 +++
 rtl/fixed_point_accumulator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
// Shared constants, Q9.7 limits and FSM encoding for the fixed-point accumulator
// and the saturation stage it shares with the Euler-step datapath.
package fixed_point_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 7;
    localparam int GUARD = 8;
    localparam int CNT_W = 8;
    localparam int ACC_W = WIDTH + GUARD;

    localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
        return {{GUARD{v[WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Clamps a guard-bit accumulator to Q9.7; o_sat flags that clamping happened.
module fixed_point_saturate
    import fixed_point_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_data,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_sat
);

    logic [ACC_W-WIDTH:0] w_upper;

    assign w_upper = i_data[ACC_W-1:WIDTH-1];

    // In range when every bit above the result sign matches it.
    always_comb begin
        o_data = i_data[WIDTH-1:0];
        o_sat  = 1'b0;
        if ((&w_upper) || (~|w_upper)) begin
            o_data = i_data[WIDTH-1:0];
            o_sat  = 1'b0;
        end else if (i_data[ACC_W-1]) begin
            o_data = Q_MIN;
            o_sat  = 1'b1;
        end else begin
            o_data = Q_MAX;
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Streaming Q9.7 accumulator: init + sum of num_terms products in a 24-bit
// accumulator, saturated once to 16 bits on entry to DONE.
module fixed_point_accumulator
    import fixed_point_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [WIDTH-1:0] init_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             busy
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_sticky;
    logic                    w_sticky_nxt;
    logic [WIDTH-1:0]        r_out_data;
    logic                    r_out_ovf;
    logic [WIDTH-1:0]        w_sat_data;
    logic                    w_sat;
    logic                    w_start_ok;
    logic                    w_xfer;
    logic                    w_enter_done;

    assign w_start_ok   = (r_state == IDLE) && start;
    assign w_xfer       = (r_state == ACCUM) && in_valid;
    assign w_enter_done = (w_state_nxt == DONE) && (r_state != DONE);

    // Saturating the next accumulator value lets the result register on DONE entry.
    fixed_point_saturate u_sat (
        .i_data (w_acc_nxt),
        .o_data (w_sat_data),
        .o_sat  (w_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_terms != {CNT_W{1'b0}}) ? ACCUM : DONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCUM: begin
                if (w_xfer && (r_cnt == CNT_W'(1))) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next accumulator, counter and sticky flag.
    always_comb begin
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_sticky_nxt = r_sticky;
        if (w_start_ok) begin
            w_acc_nxt    = sext(init_value);
            w_cnt_nxt    = num_terms;
            w_sticky_nxt = 1'b0;
        end else if (w_xfer) begin
            w_acc_nxt    = r_acc + sext(in_data);
            w_cnt_nxt    = r_cnt - CNT_W'(1);
            w_sticky_nxt = r_sticky | in_overflow;
        end else begin
            w_acc_nxt    = r_acc;
            w_cnt_nxt    = r_cnt;
            w_sticky_nxt = r_sticky;
        end
    end

    // Datapath registers; the result is captured only on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= {ACC_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_sticky   <= 1'b0;
            r_out_data <= {WIDTH{1'b0}};
            r_out_ovf  <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sticky <= w_sticky_nxt;
            if (w_enter_done) begin
                r_out_data <= w_sat_data;
                r_out_ovf  <= w_sticky_nxt | w_sat;
            end else begin
                r_out_data <= r_out_data;
                r_out_ovf  <= r_out_ovf;
            end
        end
    end

    // Output decode.
    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        out_data     = r_out_data;
        out_overflow = r_out_ovf;
        case (r_state)
            IDLE:    busy = 1'b0;
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule
